ioctl_rom_loader: RTL
=====================

# ioctl_rom_loader

Sits between the HPS download port and the arcade core, on the 53.6 MHz system clock. Splits the ioctl byte stream by index:
- index 0 ROM bytes are decoded into a region and offset, buffered in a small FIFO and handed to the core over a valid/ready handshake.
- index 254 bytes become DIP switch registers.
- index 1, address 0 becomes the game-select byte.

It throttles the HPS with `ioctl_wait` and produces the core hold-in-reset and download-done flags.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: ROM FIFO entries; power of two, ≥ 2.
- `REGION_BASE`, {8{25'h1FFFFFF}} except [0]=0: packed 8×25-bit region start addresses, ascending. Unused regions are all-ones.

Ports:
- `clk_53p6` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `ioctl_download` in 1: download in progress.
- `ioctl_index` in 8: download index.
- `ioctl_wr` in 1: byte strobe, one cycle.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: stall request to HPS.
- `rom_valid` out 1: FIFO head valid.
- `rom_ready` in 1: core accepts head.
- `rom_region` out 3: head region number.
- `rom_offset` out 25: head address minus region base.
- `rom_data` out 8: head byte.
- `dsw1` out 8: DIP byte 0.
- `dsw2` out 8: DIP byte 1.
- `game` out 8: game select.
- `core_hold` out 1: keep core in reset.
- `rom_done` out 1: ROM load finished.
- `overflow` out 1: sticky, a byte was dropped.
- `rom_sum` out 16: ROM checksum (see Configuration).

## Operation
- Reset values of all outputs:
  - `ioctl_wait`, `rom_valid`, `rom_done`, `overflow` = 0.
  - `core_hold` = 1.
  - `dsw1` = `dsw2` = 8'hFF.
  - `game` = 0.
  - `rom_sum` = 0.
  - `rom_region`, `rom_offset`, `rom_data` = 0.
- DIP capture: `ioctl_wr` & index 254 & `ioctl_addr[24:3]`==0 → addr[2:0]=0 loads `dsw1`, addr[2:0]=1 loads `dsw2`; addr[2:0]=2..7 ignored.
- Game capture: `ioctl_wr` & index 1 & `ioctl_addr`==0 → `game` <= `ioctl_dout`. Other index-1 bytes ignored.
- ROM push: `ioctl_wr` & index 0.
  - Region = highest i with addr ≥ `REGION_BASE[i]`; offset = addr − base (25-bit, never negative).
  - {region, offset, data} is written into the FIFO.
- FIFO full with simultaneous pop: the push is accepted.
- FIFO full without pop: the byte is dropped and `overflow` is set; it clears only on reset.
- Pop: `rom_valid` & `rom_ready` advances the head. `rom_*` outputs are stable while `rom_valid` & !`rom_ready`.
- `ioctl_wait` (registered) = FIFO count ≥ `FIFO_DEPTH`−1 after this cycle's push/pop. This guarantees room for one in-flight byte.
- Load state machine (states IDLE, LOAD, DRAIN, DONE):
  - IDLE → LOAD on `ioctl_download` & index 0. This clears `rom_done` and the checksum.
  - LOAD → DRAIN on `ioctl_download` falling.
  - DRAIN → DONE when the FIFO is empty.
  - DONE → LOAD on a new index-0 download.
- `core_hold` = 1 in IDLE, LOAD, DRAIN; 0 in DONE. `rom_done` = 1 only in DONE.
- Downloads with index ≠ 0 never change state.
- Reset mid-download: FIFO is flushed, state returns to IDLE, `game` and DIP registers return to reset values.

## Timing
- ROM byte latency: `ioctl_wr` at cycle N into an empty FIFO → `rom_valid` high at N+1.
- Throughput: one byte per cycle when `rom_ready` is held high.
- DIP and game registers update at the edge following `ioctl_wr`.
- `ioctl_wait` follows the count with one register stage.
- DONE is entered at the edge after the last pop that occurs with `ioctl_download` low.
- `core_hold` falls and `rom_done` rises on that same edge.

## Configuration
- Macro `IOCTL_LOADER_CHECKSUM_EN`.
- Defined: `rom_sum` accumulates the 16-bit wraparound sum of every accepted ROM byte at pop time. Dropped bytes are not summed. It is cleared on entry to LOAD and holds in DONE.
- Undefined: the accumulator is removed and `rom_sum` is tied to 16'h0000.

## Test plan
- Reset, then index-254 writes of 8'h3C at addr 0, 8'hA5 at addr 1, 8'h00 at addr 7 → `dsw1`=3C, `dsw2`=A5, no other change. Index-1 write of 8'h02 at addr 0 → `game`=02.
- `REGION_BASE[1]`=25'h8000; ROM bytes 8'h11 at 25'h7FFF and 8'h22 at 25'h8003 with `rom_ready`=1 → outputs {0, 7FFF, 11} then {1, 0003, 22}, each one cycle after its write.
- `rom_ready`=0, `FIFO_DEPTH`=4, four writes → `ioctl_wait` high after the third. A fifth write → dropped, `overflow`=1, head byte unchanged.
- Full load of 16 bytes 0x01..0x10, then `ioctl_download` falls with 3 bytes still queued → `core_hold` stays 1 until the last pop; the next edge gives `rom_done`=1. With the macro defined, `rom_sum`=16'h0088.
- `reset` asserted mid-LOAD with 2 bytes queued → `rom_valid`=0, `core_hold`=1, `dsw1`=FF immediately. No pops occur after `reset` is released.
- Simultaneous push and pop on a full FIFO → byte accepted, `overflow` stays 0, count unchanged.

Source files
------------

// File: rtl/ioctl_rom_loader.sv
// ---------------------------------------------------------------------------
// ioctl_rom_loader
//
// Bridges the HPS ioctl download port to the arcade core on the 53.6 MHz
// system clock. The byte stream is split by ioctl_index:
//   index 0   : ROM bytes, decoded into {region, offset}, queued in a small
//               FIFO and offered to the core over a valid/ready handshake.
//   index 254 : DIP switch bytes (address 0 -> dsw1, address 1 -> dsw2).
//   index 1   : address 0 carries the game-select byte.
// The HPS is throttled with ioctl_wait so that one in-flight byte always
// has room. A small load state machine (IDLE/LOAD/DRAIN/DONE) holds the
// core in reset until every ROM byte has been handed over.
//
// Optional feature macro: IOCTL_LOADER_CHECKSUM_EN
//   defined   : rom_sum is a 16-bit wraparound sum of every popped ROM byte,
//               cleared on entry to LOAD and frozen in DONE.
//   undefined : no accumulator, rom_sum is tied to zero.
//
// Parameters
//   FIFO_DEPTH  : ROM FIFO entries (power of two, >= 2).
//   REGION_BASE : packed 8 x 25-bit ascending region start addresses,
//                 [0] must be zero, unused regions all-ones.
//
// Ports
//   clk_53p6        in   system clock
//   reset           in   asynchronous active-high reset
//   ioctl_download  in   download in progress
//   ioctl_index     in   download index
//   ioctl_wr        in   single-cycle byte strobe
//   ioctl_addr      in   byte address
//   ioctl_dout      in   byte data
//   ioctl_wait      out  stall request to the HPS
//   rom_valid       out  FIFO head valid
//   rom_ready       in   core accepts the head entry
//   rom_region      out  head region number
//   rom_offset      out  head address minus its region base
//   rom_data        out  head byte
//   dsw1, dsw2      out  DIP switch bytes
//   game            out  game-select byte
//   core_hold       out  keep the core in reset
//   rom_done        out  ROM load finished
//   overflow        out  sticky: a ROM byte was dropped
//   rom_sum         out  ROM checksum (zero when the feature is disabled)
// ---------------------------------------------------------------------------
module ioctl_rom_loader #(
  parameter int unsigned       FIFO_DEPTH  = 4,
  parameter logic [8*25-1:0]   REGION_BASE = {{7{25'h1FFFFFF}}, 25'h0000000}
) (
  input  logic        clk_53p6,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        rom_valid,
  input  logic        rom_ready,
  output logic [2:0]  rom_region,
  output logic [24:0] rom_offset,
  output logic [7:0]  rom_data,
  output logic [7:0]  dsw1,
  output logic [7:0]  dsw2,
  output logic [7:0]  game,
  output logic        core_hold,
  output logic        rom_done,
  output logic        overflow,
  output logic [15:0] rom_sum
);

  localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam int unsigned      ENTRY_W  = 3 + 25 + 8;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LVL = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Highest region whose base is <= addr; region 0 starts at zero so the
  // returned offset is never negative.
  function automatic logic [27:0] decode_addr(input logic [24:0] addr);
    logic [2:0]  reg_n;
    logic [24:0] base;
    reg_n = 3'd0;
    base  = REGION_BASE[24:0];
    for (int i = 1; i < 8; i++) begin
      if (addr >= REGION_BASE[i*25 +: 25]) begin
        reg_n = 3'(i);
        base  = REGION_BASE[i*25 +: 25];
      end
    end
    return {reg_n, addr - base};
  endfunction

  // ---------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------
  state_t             state_q, state_d;
  logic               dl_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wait_q, wait_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         dsw1_q, dsw1_d;
  logic [7:0]         dsw2_q, dsw2_d;
  logic [7:0]         game_q, game_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               full;
  logic [27:0]        push_loc;
  logic [ENTRY_W-1:0] head;

  assign head     = mem_q[rd_ptr_q];
  assign full     = (count_q == DEPTH_C);
  assign push_req = ioctl_wr && (ioctl_index == 8'd0);
  assign pop      = rom_valid && rom_ready;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign push_loc = decode_addr(ioctl_addr);

  // FIFO pointer / occupancy next state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) overflow_d = 1'b1;
    // Asserting at DEPTH-1 leaves one slot for a byte already in flight.
    wait_d = (count_d >= WAIT_LVL);
  end

  // DIP switch and game-select capture
  always_comb begin
    dsw1_d = dsw1_q;
    dsw2_d = dsw2_q;
    game_d = game_q;
    if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0)) begin
      if (ioctl_addr[2:0] == 3'd0) dsw1_d = ioctl_dout;
      if (ioctl_addr[2:0] == 3'd1) dsw2_d = ioctl_dout;
    end
    if (ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0)) begin
      game_d = ioctl_dout;
    end
  end

  // Load state machine: next state and Moore outputs
  always_comb begin
    state_d   = state_q;
    core_hold = 1'b1;
    rom_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ioctl_download && (ioctl_index == 8'd0)) state_d = LOAD;
      end
      LOAD: begin
        if (dl_q && !ioctl_download) state_d = DRAIN;
      end
      DRAIN: begin
        if (count_q == '0) state_d = DONE;
      end
      DONE: begin
        core_hold = 1'b0;
        rom_done  = 1'b1;
        if (ioctl_download && (ioctl_index == 8'd0)) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_53p6 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dl_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= 1'b0;
      overflow_q <= 1'b0;
      dsw1_q     <= 8'hFF;
      dsw2_q     <= 8'hFF;
      game_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      dl_q       <= ioctl_download;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      overflow_q <= overflow_d;
      dsw1_q     <= dsw1_d;
      dsw2_q     <= dsw2_d;
      game_q     <= game_d;
    end
  end

  // FIFO storage carries data only; validity comes from count_q.
  always_ff @(posedge clk_53p6) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_loc, ioctl_dout};
  end

`ifdef IOCTL_LOADER_CHECKSUM_EN
  // ---------------------------------------------------------------------
  // Checksum of bytes as they leave the FIFO
  // ---------------------------------------------------------------------
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if ((state_q != LOAD) && (state_d == LOAD)) sum_d = 16'h0000;
    else if (pop && (state_q != DONE))          sum_d = sum_q + {8'h00, head[7:0]};
  end

  always_ff @(posedge clk_53p6 or posedge reset) begin
    if (reset) sum_q <= 16'h0000;
    else       sum_q <= sum_d;
  end

  assign rom_sum = sum_q;
`else
  assign rom_sum = 16'h0000;
`endif

  // Outputs; the head fields read as zero whenever the FIFO is empty.
  assign rom_valid  = (count_q != '0);
  assign rom_region = rom_valid ? head[35:33] : 3'd0;
  assign rom_offset = rom_valid ? head[32:8]  : 25'd0;
  assign rom_data   = rom_valid ? head[7:0]   : 8'd0;
  assign ioctl_wait = wait_q;
  assign overflow   = overflow_q;
  assign dsw1       = dsw1_q;
  assign dsw2       = dsw2_q;
  assign game       = game_q;

endmodule
